ep_turn_arbiter: RTL and testbench
==================================

EP_TURN_ARBITER -- requirements
Module: ep_turn_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of round-robin requesters (legal 2..8).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, cycles allowed from turn pulse to driven assertion (legal 2..255).
REQ-003 SHALL have port trn_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_CH  per-channel request for endpoint access.
REQ-006 SHALL have port driven  input  NUM_CH  per-channel "currently driving endpoint" flag.
REQ-007 SHALL have port turn  output  NUM_CH  per-channel one-cycle grant pulse, registered.
REQ-008 SHALL have port prio_req  input  1  priority-channel request (interrupt controller class).
REQ-009 SHALL have port prio_driven  input  1  priority channel driving endpoint.
REQ-010 SHALL have port prio_turn  output  1  priority-channel one-cycle grant pulse, registered.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse when a granted channel fails to assert driven in time.
REQ-012 SHALL have port err_ch  output  4  index of timed-out channel (NUM_CH = priority channel), held until next timeout.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, ACK.
REQ-014 IDLE: SHALL issue a grant only in a cycle where all driven bits and prio_driven are 0 and at least one of req/prio_req is 1; otherwise remain in IDLE.
REQ-015 Grant selection: if prio_req=1 and (last grant was round-robin or no req bit set), SHALL grant priority; else SHALL grant first set req bit searching upward from pointer ptr, wrapping NUM_CH-1 -> 0.
REQ-016 SHALL keep flag last_was_prio: set on priority grant, cleared on round-robin grant; priority and round-robin thus alternate under continuous contention.
REQ-017 On round-robin grant to channel k, ptr SHALL become (k+1) mod NUM_CH; priority grants SHALL not change ptr.
REQ-018 Latency: grant decision in IDLE at cycle t SHALL drive the chosen turn/prio_turn high in cycle t+1 only (GRANT state), exactly one bit high, then low.
REQ-019 GRANT SHALL always move to ACK next cycle and clear timeout counter to 1.
REQ-020 ACK: when granted channel's driven (or prio_driven) is 1, SHALL return to IDLE next cycle.
REQ-021 ACK: counter SHALL increment each cycle driven stays 0; on reaching ACK_TIMEOUT SHALL pulse timeout_err one cycle, load err_ch, return to IDLE; ptr/last_was_prio keep grant-time values.
REQ-022 Driven of a non-granted channel rising in ACK SHALL be ignored for acknowledgement; IDLE's all-low check covers it.
REQ-023 req/prio_req changes during GRANT/ACK SHALL have no effect until next IDLE evaluation.
REQ-024 turn and prio_turn SHALL never be high in the same cycle; at most one grant per 3 cycles.
REQ-025 Counter width SHALL be 8 bits; no wrap permitted (timeout fires first).

Reset
REQ-026 During reset: turn=0, prio_turn=0, timeout_err=0, err_ch=0, ptr=0, last_was_prio=0, counter=0, state=IDLE.
REQ-027 Reset asserted in any state SHALL take effect next edge, aborting grant/ACK without a timeout pulse.
REQ-028 First grant after reset with req=all ones and prio_req=0 SHALL go to channel 0.

Verification
REQ-029 NUM_CH=2, req=11, prio_req=0, driven echoes turn for 2 cycles: grants alternate turn[0], turn[1], turn[0], each pulse one cycle.
REQ-030 NUM_CH=4, req=1111, prio_req=1 continuously, driven echoes: grant order prio, ch0, prio, ch1, prio, ch2.
REQ-031 ACK_TIMEOUT=16, req=01, driven held 0: turn[0] pulse at t+1, timeout_err pulse 16 cycles after turn, err_ch=0, then turn[0] regranted.
REQ-032 driven[1]=1 held while req=01: no turn until driven[1] drops; first turn[0] pulse exactly one cycle after the drop-sampled cycle.
REQ-033 Reset asserted in ACK after turn[2] (NUM_CH=4): outputs zero next cycle, no timeout_err, next grant with req=1111 to ch0.
REQ-034 Only prio_req=1, req=0: repeated prio_turn pulses, ptr unchanged (subsequent req=1111 grants ch0 first).

Source files
------------

// File: rtl/ep_turn_arbiter_if.sv
// Endpoint turn-arbitration bus: request/driven flags in, grant pulses and timeout status out.
interface ep_turn_arbiter_if #(
    parameter int unsigned NUM_CH = 2
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] driven;
    logic [NUM_CH-1:0] turn;
    logic              prio_req;
    logic              prio_driven;
    logic              prio_turn;
    logic              timeout_err;
    logic [3:0]        err_ch;

    // Requester side: raises requests and reports who is driving the endpoint.
    modport master (
        output req, driven, prio_req, prio_driven,
        input  turn, prio_turn, timeout_err, err_ch
    );

    // Arbiter side.
    modport slave (
        input  req, driven, prio_req, prio_driven,
        output turn, prio_turn, timeout_err, err_ch
    );
endinterface

// File: rtl/ep_turn_arbiter.sv
// Endpoint turn arbiter: hands out one-cycle grant pulses to a priority channel and
// NUM_CH round-robin channels, then waits for the winner to assert driven or times out.
module ep_turn_arbiter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             trn_clk,
    input  logic             reset,
    ep_turn_arbiter_if.slave ep
);
    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 8;
    localparam logic [SW-1:0] PRIO_SEL  = SW'(NUM_CH);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     ptr_q;
    logic              last_was_prio_q;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     sel_q;
    logic [NUM_CH-1:0] turn_q;
    logic              prio_turn_q;
    logic              timeout_err_q;
    logic [SW-1:0]     err_ch_q;

    logic          rr_found_c;
    logic [PW-1:0] rr_idx_c;
    logic [PW-1:0] ptr_d;
    logic          all_low_c;
    logic          any_req_c;
    logic          pick_prio_c;
    logic          ack_c;
    logic [CW-1:0] cnt_inc_c;

    // First requesting channel at or above the pointer, wrapping around.
    always_comb begin
        rr_found_c = 1'b0;
        rr_idx_c   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!rr_found_c && ep.req[PW'((32'(ptr_q) + i) % NUM_CH)]) begin
                rr_found_c = 1'b1;
                rr_idx_c   = PW'((32'(ptr_q) + i) % NUM_CH);
            end
        end
    end

    assign ptr_d       = (rr_idx_c == PW'(NUM_CH - 1)) ? '0 : rr_idx_c + PW'(1);
    assign all_low_c   = ~|ep.driven && !ep.prio_driven;
    assign any_req_c   = |ep.req;
    // Priority wins unless it won last time and a round-robin channel is waiting.
    assign pick_prio_c = ep.prio_req && (!last_was_prio_q || !any_req_c);
    assign ack_c       = (sel_q == PRIO_SEL) ? ep.prio_driven : ep.driven[sel_q[PW-1:0]];
    assign cnt_inc_c   = cnt_q + CW'(1);

    // Arbitration FSM with registered grant and timeout outputs.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            last_was_prio_q <= 1'b0;
            cnt_q           <= '0;
            sel_q           <= '0;
            turn_q          <= '0;
            prio_turn_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
            err_ch_q        <= '0;
        end else begin
            turn_q        <= '0;
            prio_turn_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (all_low_c && (any_req_c || ep.prio_req)) begin
                        state_q <= GRANT;
                        if (pick_prio_c) begin
                            prio_turn_q     <= 1'b1;
                            sel_q           <= PRIO_SEL;
                            last_was_prio_q <= 1'b1;
                        end else begin
                            turn_q          <= NUM_CH'(1) << rr_idx_c;
                            sel_q           <= SW'(rr_idx_c);
                            ptr_q           <= ptr_d;
                            last_was_prio_q <= 1'b0;
                        end
                    end
                end
                GRANT: begin
                    state_q <= ACK;
                    cnt_q   <= CW'(1);
                end
                ACK: begin
                    if (ack_c) begin
                        state_q <= IDLE;
                    end else if (cnt_inc_c == CNT_LIMIT) begin
                        state_q       <= IDLE;
                        cnt_q         <= cnt_inc_c;
                        timeout_err_q <= 1'b1;
                        err_ch_q      <= sel_q;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ep.turn        = turn_q;
    assign ep.prio_turn   = prio_turn_q;
    assign ep.timeout_err = timeout_err_q;
    assign ep.err_ch      = err_ch_q;
endmodule

// File: tb/tb_ep_turn_arbiter.sv
// Randomized scoreboard bench for ep_turn_arbiter with a transaction-level reference model.
module tb_ep_turn_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AT = 6;

    logic trn_clk = 1'b0;
    logic reset   = 1'b1;

    ep_turn_arbiter_if #(.NUM_CH(N)) ep ();

    ep_turn_arbiter #(.NUM_CH(N), .ACK_TIMEOUT(AT)) dut (
        .trn_clk (trn_clk),
        .reset   (reset),
        .ep      (ep)
    );

    always #5 trn_clk = ~trn_clk;

    typedef struct {
        bit          is_to;
        int          ch;
        int unsigned edge_n;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int unsigned edge_n  = 0;

    int          m_ptr   = 0;
    bit          m_lwp   = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int unsigned m_gedge = 0;
    int          err_exp = 0;
    bit          rst_last = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
    endtask

    function automatic bit ch_driven(input int ch);
        if (ch == int'(N)) return ep.prio_driven;
        return ep.driven[ch];
    endfunction

    // Reference model: each posedge either evaluates a new grant, or tracks the
    // acknowledge window of the current one in terms of edges since the grant.
    always @(posedge trn_clk) begin
        edge_n++;
        rst_last = reset;
        if (reset) begin
            sb.delete();
            m_ptr   = 0;
            m_lwp   = 1'b0;
            m_busy  = 1'b0;
            err_exp = 0;
        end else if (m_busy) begin
            if (edge_n >= m_gedge + 2) begin
                if (ch_driven(m_owner)) begin
                    m_busy = 1'b0;
                end else if (edge_n == m_gedge + AT) begin
                    sb.push_back('{1'b1, m_owner, edge_n});
                    err_exp = m_owner;
                    m_busy  = 1'b0;
                end
            end
        end else if (ep.driven == 0 && !ep.prio_driven && (ep.req != 0 || ep.prio_req)) begin
            if (ep.prio_req && (!m_lwp || ep.req == 0)) begin
                m_owner = N;
                m_lwp   = 1'b1;
            end else begin
                bit found;
                found = 1'b0;
                for (int i = 0; i < int'(N); i++) begin
                    int c;
                    c = (m_ptr + i) % N;
                    if (!found && ep.req[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                    end
                end
                m_ptr = (m_owner + 1) % N;
                m_lwp = 1'b0;
            end
            m_busy  = 1'b1;
            m_gedge = edge_n;
            sb.push_back('{1'b0, m_owner, edge_n});
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant or timeout.
    always @(negedge trn_clk) begin
        exp_t e;
        int   obs;
        while (sb.size() > 0 && sb[0].edge_n < edge_n) begin
            e = sb.pop_front();
            check(1'b0, e.is_to ? "missing_timeout" : "missing_grant", -1, e.ch);
        end
        if (rst_last) begin
            check(ep.turn == 0 && !ep.prio_turn && !ep.timeout_err && ep.err_ch == 0,
                  "reset_outputs", int'({ep.turn, ep.prio_turn, ep.timeout_err, ep.err_ch}), 0);
        end
        if (ep.turn != 0 || ep.prio_turn) begin
            obs = int'(N);
            for (int k = 0; k < int'(N); k++) if (ep.turn[k]) obs = k;
            check(ep.prio_turn ? (ep.turn == 0) : $onehot(ep.turn), "grant_onehot",
                  int'({ep.prio_turn, ep.turn}), -1);
            if (sb.size() > 0 && sb[0].edge_n == edge_n && !sb[0].is_to) begin
                e = sb.pop_front();
                check(obs == e.ch, "grant_channel", obs, e.ch);
            end else begin
                check(1'b0, "unexpected_grant", obs, -1);
            end
        end
        if (ep.timeout_err) begin
            if (sb.size() > 0 && sb[0].edge_n == edge_n && sb[0].is_to) begin
                e = sb.pop_front();
                check(int'(ep.err_ch) == e.ch, "timeout_channel", int'(ep.err_ch), e.ch);
            end else begin
                check(1'b0, "unexpected_timeout", int'(ep.err_ch), -1);
            end
        end
        check(int'(ep.err_ch) == err_exp, "err_ch_hold", int'(ep.err_ch), err_exp);
    end

    // Stimulus and endpoint responder.
    int pend[N+1];
    int hold[N+1];
    int plen[N+1];

    initial begin
        int             mode;
        int             g;
        logic [N-1:0]   dv;
        ep.req         = '0;
        ep.prio_req    = 1'b0;
        ep.driven      = '0;
        ep.prio_driven = 1'b0;
        for (int k = 0; k <= int'(N); k++) begin
            pend[k] = -1;
            hold[k] = 0;
            plen[k] = 1;
        end
        for (int cyc = 0; cyc < 3200; cyc++) begin
            @(posedge trn_clk);
            #1;
            reset = (cyc < 3) || (cyc >= 200 && cyc < 3000 && $urandom_range(0, 299) == 0);
            if (cyc < 60)        begin ep.req = 4'hF; ep.prio_req = 1'b1; mode = 0; end
            else if (cyc < 120)  begin ep.req = 4'h1; ep.prio_req = 1'b0; mode = 1; end
            else if (cyc < 160)  begin ep.req = 4'h0; ep.prio_req = 1'b1; mode = 0; end
            else if (cyc < 200)  begin ep.req = 4'hF; ep.prio_req = 1'b0; mode = 0; end
            else if (cyc < 3000) begin
                mode = 2;
                if ($urandom_range(0, 3) == 0) begin
                    ep.req      = N'($urandom);
                    ep.prio_req = ($urandom_range(0, 2) == 0);
                end
            end else begin
                ep.req = '0; ep.prio_req = 1'b0; mode = 1;
            end
            if (ep.turn != 0 || ep.prio_turn) begin
                g = int'(N);
                for (int k = 0; k < int'(N); k++) if (ep.turn[k]) g = k;
                if (mode == 0) begin
                    pend[g] = 1; plen[g] = 1;
                end else if (mode == 2 && $urandom_range(0, 4) != 0) begin
                    pend[g] = $urandom_range(0, AT + 1);
                    plen[g] = $urandom_range(1, 3);
                end
            end
            if (mode == 2 && $urandom_range(0, 47) == 0) begin
                g = $urandom_range(0, N);
                if (hold[g] == 0) hold[g] = $urandom_range(1, 2);
            end
            for (int k = 0; k <= int'(N); k++) begin
                if (reset) begin
                    pend[k] = -1;
                    hold[k] = 0;
                end else if (pend[k] == 0) begin
                    hold[k] = plen[k];
                    pend[k] = -1;
                end else if (pend[k] > 0) begin
                    pend[k]--;
                end
            end
            dv = '0;
            for (int k = 0; k < int'(N); k++) dv[k] = (hold[k] > 0);
            ep.driven      = dv;
            ep.prio_driven = (hold[N] > 0);
            for (int k = 0; k <= int'(N); k++) if (hold[k] > 0) hold[k]--;
        end
        repeat (2) @(posedge trn_clk);
        #1;
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
